// File: rtl/sap1_controller_if.sv
// Control bundle between the SAP-1 sequencer and the datapath: the opcode and
// run/step inputs, the control word, and the T-state/halt status.
interface sap1_controller_if;
   logic [3:0] opcode;
   logic       run;
   logic       step;
   logic       cp;
   logic       ep;
   logic       lm;
   logic       ce;
   logic       li;
   logic       ei;
   logic       la;
   logic       ea;
   logic       su;
   logic       eu;
   logic       lb;
   logic       lo;
   logic [5:0] t_state;
   logic       halted;

   // Sequencer side: consumes opcode/run/step, drives the control word.
   modport master (
      input  opcode, run, step,
      output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, t_state, halted
   );

   // Datapath side: supplies opcode/run/step, consumes the control word.
   modport slave (
      output opcode, run, step,
      input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, t_state, halted
   );
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six T-states (fetch T1-T3, execute T4-T6) plus a
// sticky HALT. The control word is decoded combinationally from the registered
// state and the live opcode. Pausing holds the state and masks every load and
// increment strobe while leaving the bus enables decoded.
module sap1_controller (
   input  logic               clk,
   input  logic               reset,
   sap1_controller_if.master  ctrl
);

   typedef enum logic [2:0] {
      S_T1   = 3'd0,
      S_T2   = 3'd1,
      S_T3   = 3'd2,
      S_T4   = 3'd3,
      S_T5   = 3'd4,
      S_T6   = 3'd5,
      S_HALT = 3'd6
   } state_t;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   state_t state;
   state_t state_next;
   logic   advance;

   // Raw decode before pause masking and reset forcing.
   logic cp_raw, ep_raw, lm_raw, ce_raw, li_raw, ei_raw;
   logic la_raw, ea_raw, su_raw, eu_raw, lb_raw, lo_raw;

   // A cycle advances the sequence in free-run or on a step while paused.
   assign advance = ctrl.run | ctrl.step;

   // State register; reset restarts the sequence at T1.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_T1;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: ring T1..T6, HLT diverts T4 to HALT, HALT absorbs.
   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      if (state != S_HALT && advance) begin
         unique case (state)
            S_T1:    state_next = S_T2;
            S_T2:    state_next = S_T3;
            S_T3:    state_next = S_T4;
            S_T4:    state_next = (ctrl.opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:    state_next = S_T6;
            S_T6:    state_next = S_T1;
            default: state_next = S_T1;
         endcase
      end
   end

   // Control word decode from the current T-state and opcode.
   always_comb begin
      cp_raw = 1'b0;
      ep_raw = 1'b0;
      lm_raw = 1'b0;
      ce_raw = 1'b0;
      li_raw = 1'b0;
      ei_raw = 1'b0;
      la_raw = 1'b0;
      ea_raw = 1'b0;
      su_raw = 1'b0;
      eu_raw = 1'b0;
      lb_raw = 1'b0;
      lo_raw = 1'b0;
      unique case (state)
         S_T1: begin
            ep_raw = 1'b1;
            lm_raw = 1'b1;
         end
         S_T2: cp_raw = 1'b1;
         S_T3: begin
            ce_raw = 1'b1;
            li_raw = 1'b1;
         end
         S_T4: begin
            case (ctrl.opcode)
               OP_LDA, OP_ADD, OP_SUB: begin
                  ei_raw = 1'b1;
                  lm_raw = 1'b1;
               end
               OP_OUT: begin
                  ea_raw = 1'b1;
                  lo_raw = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (ctrl.opcode)
               OP_LDA: begin
                  ce_raw = 1'b1;
                  la_raw = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ce_raw = 1'b1;
                  lb_raw = 1'b1;
               end
               default: ;
            endcase
         end
         S_T6: begin
            case (ctrl.opcode)
               OP_ADD: begin
                  eu_raw = 1'b1;
                  la_raw = 1'b1;
               end
               OP_SUB: begin
                  eu_raw = 1'b1;
                  la_raw = 1'b1;
                  su_raw = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Output stage: reset silences everything, pause masks loads/increment only.
   always_comb begin
      ctrl.cp = ~reset & advance & cp_raw;
      ctrl.lm = ~reset & advance & lm_raw;
      ctrl.li = ~reset & advance & li_raw;
      ctrl.la = ~reset & advance & la_raw;
      ctrl.lb = ~reset & advance & lb_raw;
      ctrl.lo = ~reset & advance & lo_raw;
      ctrl.ep = ~reset & ep_raw;
      ctrl.ce = ~reset & ce_raw;
      ctrl.ei = ~reset & ei_raw;
      ctrl.ea = ~reset & ea_raw;
      ctrl.eu = ~reset & eu_raw;
      ctrl.su = ~reset & su_raw;
      ctrl.halted = (state == S_HALT);
      ctrl.t_state = 6'b000000;
      unique case (state)
         S_T1:    ctrl.t_state = 6'b000001;
         S_T2:    ctrl.t_state = 6'b000010;
         S_T3:    ctrl.t_state = 6'b000100;
         S_T4:    ctrl.t_state = 6'b001000;
         S_T5:    ctrl.t_state = 6'b010000;
         S_T6:    ctrl.t_state = 6'b100000;
         default: ctrl.t_state = 6'b000000;
      endcase
   end

endmodule

// File: tb/tb_sap1_controller.sv
// Self-checking bench for sap1_controller: a table of per-cycle vectors walks
// LDA/SUB/ADD/OUT/NOP, a pause-and-step in T3 and HLT; hand-written sequences
// cover the HALT lockout, reset exit, and a reset pulse in the middle of ADD.
module tb_sap1_controller;

   // Control word bit positions {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}.
   localparam logic [11:0] CP = 12'h800;
   localparam logic [11:0] EP = 12'h400;
   localparam logic [11:0] LM = 12'h200;
   localparam logic [11:0] CE = 12'h100;
   localparam logic [11:0] LI = 12'h080;
   localparam logic [11:0] EI = 12'h040;
   localparam logic [11:0] LA = 12'h020;
   localparam logic [11:0] EA = 12'h010;
   localparam logic [11:0] SU = 12'h008;
   localparam logic [11:0] EU = 12'h004;
   localparam logic [11:0] LB = 12'h002;
   localparam logic [11:0] LO = 12'h001;
   localparam logic [11:0] NONE = 12'h000;

   typedef struct {
      logic        run;
      logic        step;
      logic [3:0]  op;
      logic [11:0] word;
      logic [5:0]  ts;
      logic        halted;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   vec_t vecs[$];

   sap1_controller_if ctrl ();

   sap1_controller dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] word_now();
      return {ctrl.cp, ctrl.ep, ctrl.lm, ctrl.ce, ctrl.li, ctrl.ei,
              ctrl.la, ctrl.ea, ctrl.su, ctrl.eu, ctrl.lb, ctrl.lo};
   endfunction

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare the full visible state of the sequencer plus the bus rule.
   task automatic check_all(input string name, input logic [11:0] word,
                            input logic [5:0] ts, input logic halted);
      int bus_cnt;
      bus_cnt = $countones({ctrl.ep, ctrl.ce, ctrl.ei, ctrl.ea, ctrl.eu});
      check({name, ".word"}, 32'(word_now()), 32'(word));
      check({name, ".t_state"}, 32'(ctrl.t_state), 32'(ts));
      check({name, ".halted"}, 32'(ctrl.halted), 32'(halted));
      check({name, ".bus_rule"}, 32'(bus_cnt <= 1), 32'd1);
   endtask

   // Drive one cycle's inputs, check at the falling edge, then take the edge.
   task automatic cycle(input string name, input logic run, input logic step,
                        input logic [3:0] op, input logic [11:0] word,
                        input logic [5:0] ts, input logic halted);
      ctrl.run = run;
      ctrl.step = step;
      ctrl.opcode = op;
      @(negedge clk);
      check_all(name, word, ts, halted);
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic run, input logic step, input logic [3:0] op,
                      input logic [11:0] word, input logic [5:0] ts,
                      input logic halted);
      vec_t v;
      v.run = run; v.step = step; v.op = op;
      v.word = word; v.ts = ts; v.halted = halted;
      vecs.push_back(v);
   endtask

   // One instruction's fetch cycles under free-run with the given opcode.
   task automatic add_fetch(input logic [3:0] op);
      add(1, 0, op, EP | LM, 6'b000001, 0);
      add(1, 0, op, CP,      6'b000010, 0);
      add(1, 0, op, CE | LI, 6'b000100, 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ctrl.run = 1'b1;
      ctrl.step = 1'b0;
      ctrl.opcode = 4'b0000;

      // LDA
      add_fetch(4'b0000);
      add(1, 0, 4'b0000, EI | LM, 6'b001000, 0);
      add(1, 0, 4'b0000, CE | LA, 6'b010000, 0);
      add(1, 0, 4'b0000, NONE,    6'b100000, 0);
      // SUB
      add_fetch(4'b0010);
      add(1, 0, 4'b0010, EI | LM,      6'b001000, 0);
      add(1, 0, 4'b0010, CE | LB,      6'b010000, 0);
      add(1, 0, 4'b0010, EU | LA | SU, 6'b100000, 0);
      // ADD
      add_fetch(4'b0001);
      add(1, 0, 4'b0001, EI | LM, 6'b001000, 0);
      add(1, 0, 4'b0001, CE | LB, 6'b010000, 0);
      add(1, 0, 4'b0001, EU | LA, 6'b100000, 0);
      // OUT
      add_fetch(4'b1110);
      add(1, 0, 4'b1110, EA | LO, 6'b001000, 0);
      add(1, 0, 4'b1110, NONE,    6'b010000, 0);
      add(1, 0, 4'b1110, NONE,    6'b100000, 0);
      // Undefined opcode behaves as NOP
      add_fetch(4'b0111);
      add(1, 0, 4'b0111, NONE, 6'b001000, 0);
      add(1, 0, 4'b0111, NONE, 6'b010000, 0);
      add(1, 0, 4'b0111, NONE, 6'b100000, 0);
      // Pause in T3 for 5 cycles, then one step, then free-run LDA
      add(1, 0, 4'b0000, EP | LM, 6'b000001, 0);
      add(1, 0, 4'b0000, CP,      6'b000010, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 4'b0000, CE, 6'b000100, 0);
      add(0, 1, 4'b0000, CE | LI, 6'b000100, 0);
      add(0, 0, 4'b0000, EI,      6'b001000, 0);
      add(1, 0, 4'b0000, EI | LM, 6'b001000, 0);
      add(1, 0, 4'b0000, CE | LA, 6'b010000, 0);
      add(1, 0, 4'b0000, NONE,    6'b100000, 0);
      // HLT
      add_fetch(4'b1111);
      add(1, 0, 4'b1111, NONE, 6'b001000, 0);
      add(1, 0, 4'b1111, NONE, 6'b000000, 1);

      // Reset state
      reset = 1'b1;
      #2;
      check_all("reset", NONE, 6'b000001, 0);
      @(posedge clk);
      #1;
      check_all("reset_hold", NONE, 6'b000001, 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         cycle($sformatf("vec%0d", i), vecs[i].run, vecs[i].step, vecs[i].op,
               vecs[i].word, vecs[i].ts, vecs[i].halted);
      end

      // HALT ignores run/step
      for (int i = 0; i < 20; i++) begin
         cycle($sformatf("halt%0d", i), 1'(i % 2), 1'((i / 2) % 2),
               4'(i), NONE, 6'b000000, 1);
      end

      // Reset exits HALT
      reset = 1'b1;
      #1;
      check_all("halt_reset", NONE, 6'b000001, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all("halt_release", EP | LM, 6'b000001, 0);
      @(posedge clk);
      #1;

      // Reset pulse in ADD T5
      cycle("add_t2", 1, 0, 4'b0001, CP,      6'b000010, 0);
      cycle("add_t3", 1, 0, 4'b0001, CE | LI, 6'b000100, 0);
      cycle("add_t4", 1, 0, 4'b0001, EI | LM, 6'b001000, 0);
      @(negedge clk);
      check_all("add_t5", CE | LB, 6'b010000, 0);
      #1;
      reset = 1'b1;
      #1;
      check_all("mid_reset", NONE, 6'b000001, 0);
      #1;
      reset = 1'b0;
      #1;
      check_all("mid_release", EP | LM, 6'b000001, 0);
      @(posedge clk);
      #1;
      cycle("resume_t2", 1, 0, 4'b0001, CP,      6'b000010, 0);
      cycle("resume_t3", 1, 0, 4'b0001, CE | LI, 6'b000100, 0);
      cycle("resume_t4", 1, 0, 4'b0001, EI | LM, 6'b001000, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sap1_controller.md
# sap1_controller

Control sequencer for the SAP-1 datapath. A six-state ring counter (T1–T6) drives the fetch cycle, and the opcode from the instruction register drives the execute cycle. Each T-state produces one control word: load strobes for the PC, MAR, IR, A, B and output registers, and bus-enable strobes for the PC, RAM, IR, A and ALU. The block also provides free-run and single-step operation and a sticky halt.

## Interface
- No parameters; all widths are fixed by the SAP-1 architecture.
- clk  in  1  system clock; all datapath registers load on the rising edge.
- reset  in  1  asynchronous, active-high; the same reset drives the datapath registers.
- opcode  in  4  upper nibble of the instruction register; must be stable during T4–T6.
- run  in  1  1 = free-run (advance every cycle); 0 = paused, advance only on step.
- step  in  1  synchronous level, sampled each edge while run=0; 1 advances one T-state.
- cp  out  1  PC increment.
- ep  out  1  PC drives bus.
- lm  out  1  MAR load (active-high).
- ce  out  1  RAM drives bus.
- li  out  1  IR load.
- ei  out  1  IR low nibble drives bus.
- la  out  1  A load.
- ea  out  1  A drives bus.
- su  out  1  ALU subtract select.
- eu  out  1  ALU drives bus.
- lb  out  1  B load.
- lo  out  1  output register load.
- t_state  out  6  one-hot current T-state (bit0 = T1); 0 in HALT.
- halted  out  1  1 in HALT.

## Operation
- State register has states T1..T6 and HALT, encoded one-hot or binary (designer's choice). Control outputs are combinationally decoded from the registered state and `opcode`.
- **Fetch:**
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
- **Execute, by opcode:**
  - LDA 0000: T4 ei,lm; T5 ce,la; T6 none.
  - ADD 0001: T4 ei,lm; T5 ce,lb; T6 eu,la with su=0.
  - SUB 0010: T4 ei,lm; T5 ce,lb; T6 eu,la,su.
  - OUT 1110: T4 ea,lo; T5 none; T6 none.
  - HLT 1111: T4 outputs none; next state is HALT instead of T5.
  - Any other opcode: no controls in T4–T6 (NOP); the sequence continues normally.
- **Transitions:** T1→T2→…→T6→T1. HLT causes T4→HALT. HALT is absorbing: only reset exits it.
- **Bus rule:** at most one of ep, ce, ei, ea, eu is high in any cycle.
- **Pause (run=0, step=0):**
  - State holds.
  - Bus enables and su stay as decoded, so the bus stays stable.
  - All load and increment strobes (cp, lm, li, la, lb, lo) are forced to 0, so no register reloads.
- **Step:** run=0 with step=1 behaves exactly like one free-run cycle, strobes included. Holding step high steps every cycle.
- **HALT:** all control outputs 0; t_state=0; halted=1. The run and step inputs are ignored.

## Timing
- Reset asserted: state becomes T1 asynchronously. All control outputs are forced to 0 while reset is high; t_state=000001 and halted=0.
- First rising edge after reset release: T1 decode is already active before it, so that edge loads the MAR from the PC. A reset pulse in mid-instruction abandons the instruction: no partial strobes, and the restart is in T1.
- Free-run: one T-state per clock, 6 clocks per instruction. A load named in state Tn takes effect on the edge that ends Tn.
- HLT: T4 is the last active cycle; halted rises 1 clock after T4. Total 4 clocks from T1.
- Opcode is used directly, not registered. The IR is loaded on the T3→T4 edge, so the T4 decode sees the new opcode.
- A run transition 1→0 takes effect the same cycle: strobes are masked and state holds on that edge.

## Test plan
- **Reset then free-run, opcode=0000 (LDA):**
  - Cycles 1–6: {ep,lm}, {cp}, {ce,li}, {ei,lm}, {ce,la}, {}.
  - t_state walks 000001→100000, then returns to 000001.
- **SUB (0010) then ADD (0001):**
  - T6 of SUB shows eu=la=su=1.
  - T6 of ADD shows eu=la=1, su=0.
  - T5 of both shows ce=lb=1.
- **HLT (1111):**
  - T4 has no controls; halted=1 from the next cycle with t_state=0.
  - 20 further cycles with run and step toggling: all outputs stay 0.
  - reset → T1 with halted=0.
- **run=0, step=0 in T3:**
  - For 5 cycles: ce=1, li=0, t_state=000100 (held).
  - One step=1 cycle: li=1 for that cycle, then state T4.
- **OUT (1110) and undefined opcode 0111:**
  - OUT: T4 ea=lo=1; T5–T6 all 0.
  - 0111: T4–T6 all 0, then T1.
  - Every cycle has at most one bus-enable high.
- **Reset pulse in the middle of ADD T5:**
  - Outputs drop to 0 immediately.
  - After release, the sequence resumes at T1 with {ep,lm}; the interrupted ADD issues no lb or la.
